ram_stream_reader: RTL

- Read-side engine for the 1R/1W register-file RAM. It walks a contiguous address range through the RAM's combinational read port and streams each word out over a valid/ready handshake.
- Intended for memory dump/debug readout and for feeding the result unit in the single-cycle processor.
- Counterpart to the RAM write path: it reads what the processor wrote.

---
 rtl/ram_stream_reader_if.sv | 26 ++
 rtl/ram_stream_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader_if.sv
// Output stream of the RAM stream reader: one word per valid/ready handshake,
// with a marker on the final word of a transfer.
interface ram_stream_reader_if #(
    parameter int D_WIDTH = 19
);

    logic [D_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/ram_stream_reader.sv
// Read-side engine for the 1R/1W register-file RAM: walks a contiguous (wrapping)
// address range and streams each word out, accumulating a running checksum.
module ram_stream_reader #(
    parameter int D_WIDTH = 19,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [A_WIDTH-1:0]  base_addr,
    input  logic [A_WIDTH:0]    length,
    output logic [A_WIDTH-1:0]  address_read,
    input  logic [D_WIDTH-1:0]  data_read,
    ram_stream_reader_if.master stream,
    output logic                busy,
    output logic                done,
    output logic [D_WIDTH-1:0]  checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [A_WIDTH:0]   MAX_LEN  = (A_WIDTH + 1)'(A_MAX);
    localparam logic [A_WIDTH:0]   LEN_ZERO = {(A_WIDTH + 1){1'b0}};
    localparam logic [A_WIDTH:0]   LEN_ONE  = {{A_WIDTH{1'b0}}, 1'b1};
    localparam logic [A_WIDTH-1:0] ADDR_ONE = {{(A_WIDTH - 1){1'b0}}, 1'b1};

    // Requests longer than the RAM are clamped so every word is read at most once.
    function automatic logic [A_WIDTH:0] clamp_len(input logic [A_WIDTH:0] len);
        logic [A_WIDTH:0] res;
        if (len > MAX_LEN) begin
            res = MAX_LEN;
        end else begin
            res = len;
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [A_WIDTH-1:0] ptr_r;
    logic [A_WIDTH:0]   remaining_r;
    logic [D_WIDTH-1:0] out_data_r;
    logic [D_WIDTH-1:0] checksum_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               busy_r;
    logic               done_r;
    logic               handshake_s;
    logic               last_word_s;
    logic [A_WIDTH:0]   start_len_s;

    // Handshake and length decode shared by the FSM and datapath.
    always_comb begin
        handshake_s = out_valid_r && stream.out_ready;
        last_word_s = (remaining_r == LEN_ONE);
        start_len_s = clamp_len(length);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (start_len_s == LEN_ZERO) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                next_state_s = SEND;
            end
            SEND: begin
                if (handshake_s) begin
                    if (last_word_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = SEND;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath: pointer, word count, captured word and checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r       <= {A_WIDTH{1'b0}};
            remaining_r <= LEN_ZERO;
            out_data_r  <= {D_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            checksum_r  <= {D_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        ptr_r       <= base_addr;
                        remaining_r <= start_len_s;
                        checksum_r  <= {D_WIDTH{1'b0}};
                    end
                end
                FETCH: begin
                    // The word is captured here, so later RAM writes cannot alter it.
                    out_data_r  <= data_read;
                    out_valid_r <= 1'b1;
                    out_last_r  <= last_word_s;
                end
                SEND: begin
                    if (handshake_s) begin
                        checksum_r  <= checksum_r + out_data_r;
                        remaining_r <= remaining_r - LEN_ONE;
                        ptr_r       <= ptr_r + ADDR_ONE;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered from the upcoming state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
        end
    end

    assign address_read     = ptr_r;
    assign stream.out_data  = out_data_r;
    assign stream.out_valid = out_valid_r;
    assign stream.out_last  = out_last_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign checksum         = checksum_r;

endmodule
